// File: rtl/bicubic_hsum_mac.sv
// bicubic_hsum_mac: horizontal 4-tap bicubic multiply-accumulate with round, renormalise and clip to 8 bits
//   Three-stage pipeline: S1 registers the four tap products, S2 the two pair sums,
//   S3 (the output register) the rounded and clipped pixel. All stages advance together
//   on en = !out_valid_o || out_ready_i and hold together otherwise.
//   Ports:
//     clk, rst_n                        clock, asynchronous active-low reset
//     in_valid_i / in_ready_o           input handshake, in_ready_o = en
//     in_p0_i..in_p3_i                  unsigned pixels at taps -1, 0, +1, +2
//     in_w0_i..in_w3_i                  signed weights, W_FRAC fractional bits
//     in_sof_i, in_eol_i                start-of-frame / end-of-line tags carried with the beat
//     out_valid_o / out_ready_i         output handshake
//     out_pix_o, out_sof_o, out_eol_o   clipped pixel and its tags
//     clip_cnt_o                        saturating clip-event counter
//   Macro: BICUBIC_HSUM_CLIP_CNT_EN adds clip_cnt_o and its counter.
module bicubic_hsum_mac #(
    parameter int W_W    = 17,
    parameter int W_FRAC = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [7:0]            in_p0_i,
    input  logic [7:0]            in_p1_i,
    input  logic [7:0]            in_p2_i,
    input  logic [7:0]            in_p3_i,
    input  logic signed [W_W-1:0] in_w0_i,
    input  logic signed [W_W-1:0] in_w1_i,
    input  logic signed [W_W-1:0] in_w2_i,
    input  logic signed [W_W-1:0] in_w3_i,
    input  logic                  in_sof_i,
    input  logic                  in_eol_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [7:0]            out_pix_o,
    output logic                  out_sof_o,
    output logic                  out_eol_o
`ifdef BICUBIC_HSUM_CLIP_CNT_EN
    ,
    output logic [15:0]           clip_cnt_o
`endif
);
    localparam int PW   = W_W + 9;
    localparam int SW   = PW + 1;
    localparam int TW   = PW + 2;
    localparam int RW   = PW + 3;
    localparam int HALF = 1 << (W_FRAC - 1);

    logic                 en;
    logic signed [PW-1:0] prod_d [4];
    logic signed [PW-1:0] prod_q [4];
    logic                 s1_v_q, s1_sof_q, s1_eol_q;
    logic signed [SW-1:0] sa_d, sb_d, sa_q, sb_q;
    logic                 s2_v_q, s2_sof_q, s2_eol_q;
    logic signed [TW-1:0] sum;
    logic signed [RW-1:0] r;
    logic                 clip_lo, clip_hi;
    logic [7:0]           pix_d, pix_q;
    logic                 out_valid_q, out_sof_q, out_eol_q;

    always_comb begin
        en        = !out_valid_q || out_ready_i;
        prod_d[0] = PW'($signed({1'b0, in_p0_i})) * PW'(in_w0_i);
        prod_d[1] = PW'($signed({1'b0, in_p1_i})) * PW'(in_w1_i);
        prod_d[2] = PW'($signed({1'b0, in_p2_i})) * PW'(in_w2_i);
        prod_d[3] = PW'($signed({1'b0, in_p3_i})) * PW'(in_w3_i);
        sa_d      = SW'(prod_q[0]) + SW'(prod_q[1]);
        sb_d      = SW'(prod_q[2]) + SW'(prod_q[3]);
        sum       = TW'(sa_q) + TW'(sb_q);
        // one extra bit so adding the rounding half can never wrap
        r         = (RW'(sum) + RW'(HALF)) >>> W_FRAC;
        clip_lo   = r[RW-1];
        clip_hi   = !r[RW-1] && (r > RW'(255));
        pix_d     = clip_lo ? 8'd0 : clip_hi ? 8'd255 : r[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q      <= '{default: '0};
            s1_v_q      <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            sa_q        <= '0;
            sb_q        <= '0;
            s2_v_q      <= 1'b0;
            s2_sof_q    <= 1'b0;
            s2_eol_q    <= 1'b0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else if (en) begin
            prod_q      <= prod_d;
            s1_v_q      <= in_valid_i;
            s1_sof_q    <= in_sof_i;
            s1_eol_q    <= in_eol_i;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            s2_v_q      <= s1_v_q;
            s2_sof_q    <= s1_sof_q;
            s2_eol_q    <= s1_eol_q;
            pix_q       <= pix_d;
            out_valid_q <= s2_v_q;
            out_sof_q   <= s2_sof_q;
            out_eol_q   <= s2_eol_q;
        end
    end

`ifdef BICUBIC_HSUM_CLIP_CNT_EN
    logic [15:0] clip_cnt_d, clip_cnt_q;

    // counted on the S3 load only, so a beat held through a stall is seen once
    always_comb begin
        clip_cnt_d = !(en && s2_v_q) ? clip_cnt_q :
                     s2_sof_q ? {15'd0, clip_lo || clip_hi} :
                     ((clip_lo || clip_hi) && !(&clip_cnt_q)) ? clip_cnt_q + 16'd1 : clip_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clip_cnt_q <= '0;
        else clip_cnt_q <= clip_cnt_d;
    end

    assign clip_cnt_o = clip_cnt_q;
`endif

    assign in_ready_o  = en;
    assign out_valid_o = out_valid_q;
    assign out_pix_o   = pix_q;
    assign out_sof_o   = out_sof_q;
    assign out_eol_o   = out_eol_q;
endmodule

// File: tb/tb_bicubic_hsum_mac.sv
// tb_bicubic_hsum_mac: self-checking bench for bicubic_hsum_mac against an arithmetic reference model
module tb_bicubic_hsum_mac;
    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic [7:0]         in_p0_i = '0, in_p1_i = '0, in_p2_i = '0, in_p3_i = '0;
    logic signed [16:0] in_w0_i = '0, in_w1_i = '0, in_w2_i = '0, in_w3_i = '0;
    logic               in_sof_i = 1'b0, in_eol_i = 1'b0;
    logic               out_valid_o;
    logic               out_ready_i = 1'b1;
    logic [7:0]         out_pix_o;
    logic               out_sof_o, out_eol_o;
`ifdef BICUBIC_HSUM_CLIP_CNT_EN
    logic [15:0]        clip_cnt_o;
`endif

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    always #5 clk = ~clk;

    bicubic_hsum_mac dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_p0_i     (in_p0_i),
        .in_p1_i     (in_p1_i),
        .in_p2_i     (in_p2_i),
        .in_p3_i     (in_p3_i),
        .in_w0_i     (in_w0_i),
        .in_w1_i     (in_w1_i),
        .in_w2_i     (in_w2_i),
        .in_w3_i     (in_w3_i),
        .in_sof_i    (in_sof_i),
        .in_eol_i    (in_eol_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pix_o   (out_pix_o),
        .out_sof_o   (out_sof_o),
        .out_eol_o   (out_eol_o)
`ifdef BICUBIC_HSUM_CLIP_CNT_EN
        ,
        .clip_cnt_o  (clip_cnt_o)
`endif
    );

    // weighted sum in real units, rounded half up with floor semantics, then clipped
    function automatic logic [7:0] ref_pix(input int p0, p1, p2, p3, w0, w1, w2, w3);
        longint s, r;
        s = longint'(p0) * w0 + longint'(p1) * w1 + longint'(p2) * w2 + longint'(p3) * w3 + 8192;
        r = s >= 0 ? s / 16384 : -((-s + 16383) / 16384);
        return r < 0 ? 8'd0 : r > 255 ? 8'd255 : 8'(r);
    endfunction

    // inputs change only at posedge+1, so negedge sees what the next edge will act on
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid_i && in_ready_o)
                exp_q.push_back({ref_pix(in_p0_i, in_p1_i, in_p2_i, in_p3_i,
                                         in_w0_i, in_w1_i, in_w2_i, in_w3_i), in_sof_i, in_eol_i});
            if (out_valid_o && out_ready_i)
                obs_q.push_back({out_pix_o, out_sof_o, out_eol_o});
        end
    end

    task automatic send(input int p0, p1, p2, p3, w0, w1, w2, w3, input logic sof, eol);
        int n = 0;
        in_p0_i = 8'(p0); in_p1_i = 8'(p1); in_p2_i = 8'(p2); in_p3_i = 8'(p3);
        in_w0_i = 17'(w0); in_w1_i = 17'(w1); in_w2_i = 17'(w2); in_w3_i = 17'(w3);
        in_sof_i = sof; in_eol_i = eol; in_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready_o) break;
            if (++n > 1000) begin
                checks++; errors++;
                $display("FAIL send_timeout in_ready stuck low for %0d cycles", n);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        while (obs_q.size() < exp_q.size() && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid_o); end
        checks++; if (out_pix_o !== 8'd0) begin errors++; $display("FAIL reset_pix got=%0d want=0", out_pix_o); end
        checks++; if ({out_sof_o, out_eol_o} !== 2'b00) begin errors++; $display("FAIL reset_tags got=%b want=00", {out_sof_o, out_eol_o}); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready_o); end
`ifdef BICUBIC_HSUM_CLIP_CNT_EN
        checks++; if (clip_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_clipcnt got=%0d want=0", clip_cnt_o); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unity();
        clear_q();
        send(10, 200, 30, 40, 0, 16384, 0, 0, 1'b1, 1'b1);
        in_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL unity_lat1 valid got=%b want=0", out_valid_o); end
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL unity_lat2 valid got=%b want=0", out_valid_o); end
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL unity_lat3 valid got=%b want=1", out_valid_o); end
        checks++; if (out_pix_o !== 8'd200) begin errors++; $display("FAIL unity_pix got=%0d want=200", out_pix_o); end
        checks++; if ({out_sof_o, out_eol_o} !== 2'b11) begin errors++; $display("FAIL unity_tags got=%b want=11", {out_sof_o, out_eol_o}); end
        drain();
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL unity_count got=%0d want=1", obs_q.size()); end
    endtask

    task automatic test_rounding();
        logic [7:0] want [3] = '{8'd2, 8'd1, 8'd0};
        clear_q();
        send(0, 3, 0, 0, 0, 8192, 0, 0, 1'b0, 1'b0);
        send(0, 1, 0, 0, 0, 8192, 0, 0, 1'b0, 1'b0);
        send(0, 1, 0, 0, 0, -8192, 0, 0, 1'b0, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 3) begin errors++; $display("FAIL round_count got=%0d want=3", obs_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i].pix !== want[i]) begin errors++; $display("FAIL round_%0d got=%0d want=%0d", i, obs_q[i].pix, want[i]); end
        end
    endtask

    task automatic test_clipping();
        clear_q();
        send(255, 0, 0, 0, -2048, 18432, 0, 0, 1'b1, 1'b0);
        send(0, 255, 0, 0, 0, 20480, 0, 0, 1'b0, 1'b1);
        drain();
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("FAIL clip_count got=%0d want=2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].pix !== 8'd0) begin errors++; $display("FAIL clip_low got=%0d want=0", obs_q[0].pix); end
            checks++; if (obs_q[1].pix !== 8'd255) begin errors++; $display("FAIL clip_high got=%0d want=255", obs_q[1].pix); end
        end
`ifdef BICUBIC_HSUM_CLIP_CNT_EN
        checks++; if (clip_cnt_o !== 16'd2) begin errors++; $display("FAIL clip_cnt got=%0d want=2", clip_cnt_o); end
`endif
    endtask

    task automatic test_backpressure();
        logic [7:0] held = '0;
        clear_q();
        fork
            begin
                for (int i = 1; i <= 20; i++) send(0, i, 0, 0, 0, 16384, 0, 0, i == 1, i == 20);
                in_valid_i = 1'b0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    out_ready_i = !(c >= 5 && c <= 9);
                    @(negedge clk);
                    if (!out_ready_i) begin
                        checks++;
                        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready c=%0d got=%b want=0", c, in_ready_o); end
                        if (c > 5) begin
                            checks++;
                            if (out_pix_o !== held) begin errors++; $display("FAIL bp_hold c=%0d got=%0d want=%0d", c, out_pix_o, held); end
                        end
                        held = out_pix_o;
                    end
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        checks++;
        if (obs_q.size() != 20) begin errors++; $display("FAIL bp_count got=%0d want=20", obs_q.size()); end
        else for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs_q[i] !== beat_t'{8'(i + 1), i == 0, i == 19}) begin
                errors++; $display("FAIL bp_beat_%0d got=%h want=%h", i, obs_q[i], beat_t'{8'(i + 1), i == 0, i == 19});
            end
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        clear_q();
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int w [4];
                    for (int k = 0; k < 4; k++)
                        w[k] = $urandom_range(0, 4) == 0 ? ($urandom_range(0, 1) ? -65536 : 65535)
                                                         : int'($urandom_range(0, 26000)) - 4000;
                    if ($urandom_range(0, 5) == 0) begin
                        in_valid_i = 1'b0;
                        @(posedge clk); #1;
                    end
                    send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                         w[0], w[1], w[2], w[3], $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
                end
                in_valid_i = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready_i = $urandom_range(0, 3) != 0;
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat_%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        clear_q();
        send(0, 50, 0, 0, 0, 16384, 0, 0, 1'b1, 1'b0);
        send(0, 60, 0, 0, 0, 16384, 0, 0, 1'b0, 1'b0);
        send(0, 70, 0, 0, 0, 16384, 0, 0, 1'b0, 1'b1);
        in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b want=0", out_valid_o); end
        checks++; if (out_pix_o !== 8'd0) begin errors++; $display("FAIL mid_pix got=%0d want=0", out_pix_o); end
        checks++; if ({out_sof_o, out_eol_o} !== 2'b00) begin errors++; $display("FAIL mid_tags got=%b want=00", {out_sof_o, out_eol_o}); end
        clear_q();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_ghost got=%0d beats want=0", obs_q.size()); end
        send(0, 77, 0, 0, 0, 16384, 0, 0, 1'b0, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL mid_count got=%0d want=1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].pix !== 8'd77) begin errors++; $display("FAIL mid_pix_after got=%0d want=77", obs_q[0].pix); end
        end
    endtask

`ifdef BICUBIC_HSUM_CLIP_CNT_EN
    task automatic test_counter();
        clear_q();
        send(0, 255, 0, 0, 0, 20480, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 200, 0, 0, 0, 32768, 0, 0, 1'b0, 1'b0);
        send(0, 100, 0, 0, 0, 16384, 0, 0, 1'b0, 1'b0);
        drain();
        checks++; if (clip_cnt_o !== 16'd5) begin errors++; $display("FAIL cnt_accum got=%0d want=5", clip_cnt_o); end
        send(0, 10, 0, 0, 0, 16384, 0, 0, 1'b1, 1'b0);
        drain();
        checks++; if (clip_cnt_o !== 16'd0) begin errors++; $display("FAIL cnt_sof_clear got=%0d want=0", clip_cnt_o); end
        for (int i = 0; i < 70000; i++) send(255, 0, 0, 0, -16384, 0, 0, 0, 1'b0, 1'b0);
        drain();
        checks++; if (clip_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got=%0d want=65535", clip_cnt_o); end
        clear_q();
    endtask
`endif

    initial begin
        test_reset();
        test_unity();
        test_rounding();
        test_clipping();
        test_backpressure();
        test_random();
        test_reset_midstream();
`ifdef BICUBIC_HSUM_CLIP_CNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bicubic_hsum_mac.md
# bicubic_hsum_mac

Horizontal 4-tap accumulation stage of the bicubic scaler. It sits directly downstream of the four per-tap bicubic weight generators, one of them per distance x0..x3. It multiplies four neighbouring 8-bit pixels by their signed kernel weights, sums the products, then rounds, renormalises and clips the result to an 8-bit output pixel. The data path is a 3-stage pipeline with a valid/ready handshake and a global stall.

## Interface
- W_W, 17, signed weight width in two's complement; the weight generators' outputs are sign-extended to this width.
- W_FRAC, 14, weight fractional bits; unity weight = 1<<W_FRAC.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_p0..in_p3  in  8 each  unsigned pixels at taps -1, 0, +1, +2.
- in_w0..in_w3  in  W_W each  signed weights for the matching taps.
- in_sof, in_eol  in  1 each  start-of-frame and end-of-line tags, carried with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_pix  out  8  clipped result pixel.
- out_sof, out_eol  out  1 each  tags aligned to out_pix.
- clip_cnt  out  16  saturation event count; present only with the macro.

## Operation
- Advance enable: en = !out_valid || out_ready. in_ready = en.
- A beat is accepted when in_valid && in_ready.
- All three stages advance together when en = 1 and hold entirely when en = 0. Bubbles are not compressed during a stall.
- Each stage carries a valid bit plus the sof and eol tags.
- Stage 1 (S1):
  - Each pixel is zero-extended to 9 bits signed.
  - prod_i = pix_i * w_i, signed, W_W+9 = 26 bits.
  - S1 valid = accepted beat.
- Stage 2 (S2):
  - sa = prod0 + prod1 and sb = prod2 + prod3, each 27 bits signed.
- Stage 3 (S3, the output register):
  - sum = sa + sb, 28 bits signed.
  - r = (sum + (1<<(W_FRAC-1))) >>> W_FRAC, arithmetic shift, round half up.
  - out_pix = 0 if r < 0; 255 if r > 255; otherwise r[7:0].
- Arithmetic widths are chosen so no intermediate overflows for any input, including every weight at the W_W extremes.
- A beat is consumed downstream when out_valid && out_ready.
- Reset values:
  - All stage valid bits, out_valid, out_pix, out_sof, out_eol and clip_cnt = 0.
  - in_ready = 1 after reset, because out_valid = 0.
- Asynchronous reset mid-stream discards every in-flight beat. No output beat appears until new input is accepted.

## Timing
- A beat accepted at edge E0 is registered in S1 at E0, S2 at E1 and S3 at E2. out_valid is high from E2 onward.
- Latency is 3 cycles with no stall.
- Throughput is 1 beat/clk while out_ready = 1.
- While out_ready = 0 and out_valid = 1:
  - in_ready = 0, combinationally from out_ready.
  - out_pix and the out tags stay stable.
  - No beat is lost or duplicated.
- in_ready depends combinationally on out_ready. There is no other combinational input-to-output path.

## Configuration
- BICUBIC_HSUM_CLIP_CNT_EN defined:
  - clip_cnt is a 16-bit counter that increments once per S3 load of a valid beat whose r was clipped, high or low.
  - It saturates at 16'hFFFF.
  - It clears to 0 on an S3 load of a valid beat with sof = 1, and that beat's own clip is counted, giving 1.
  - A beat that stays held in S3 during a stall is counted once.
- BICUBIC_HSUM_CLIP_CNT_EN undefined:
  - The clip_cnt port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Unity passthrough: w = (0, 16384, 0, 0), p = (10, 200, 30, 40), one beat → out_pix = 200, 3 cycles after accept, with tags preserved.
- Rounding: w = (0, 8192, 0, 0), p1 = 3 → 1.5 rounds to 2. With p1 = 1 → 0.5 rounds to 1. With w1 = -8192, p1 = 1 → -0.5 rounds to 0.
- Clipping: w = (-2048, 18432, 0, 0), p = (255, 0, 0, 0) → 0. w = (0, 20480, 0, 0), p1 = 255 → 255. With the macro defined, clip_cnt = 2.
- Backpressure: stream 20 beats with incrementing p1 and unity w1, and hold out_ready low for cycles 5-9 → output sequence complete, in order, no duplicates, in_ready low during the stall.
- Reset mid-stream: assert rst_n low with 3 beats in flight → all outputs 0 immediately; after release, only newly accepted beats emerge.
- Counter: the macro is defined, clipping beats are sent, then a beat with sof = 1 that does not clip → clip_cnt = 0. Forcing 70000 clipping beats → clip_cnt holds at 65535.
